// File: rtl/rr_onehot_arbiter.sv
// rr_onehot_arbiter: round-robin arbiter with a registered one-hot grant.
// A grant is held until its owner pulses done or drops its request. There is
// always at least one idle cycle between two grants. The search pointer moves
// to the index just past each winner, so every requester gets a turn.
// Optional build macro RR_ONEHOT_ARBITER_CHECK_EN adds an internal checker on
// the registered grant: it tests for one-hot-or-zero, for a gnt_id that
// matches gnt, and for gnt_valid == |gnt. Any violation sets a sticky err
// flag. Without the macro, err is tied low.
module rr_onehot_arbiter #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         done,
    output logic [N-1:0] gnt,
    output logic         gnt_valid,
    output logic [W-1:0] gnt_id,
    output logic         err
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t       state, state_next;
    logic [W-1:0] ptr, ptr_next;
    logic [N-1:0] gnt_next;
    logic [W-1:0] id_next;
    logic         valid_next;

    // Priority search results.
    logic [W:0]   idx;
    logic         found;
    logic [W-1:0] winner;
    logic         release_cond;

    // Scan from ptr upward, wrapping modulo N. The first requester hit wins.
    // The index has one spare bit, so ptr + k never overflows before the wrap.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = 0; k < N; k++) begin
            idx = {1'b0, ptr} + (W+1)'(k);
            if (idx >= (W+1)'(N))
                idx = idx - (W+1)'(N);
            if (!found && req[idx[W-1:0]]) begin
                found  = 1'b1;
                winner = idx[W-1:0];
            end
        end
    end

    // Release the owner on done, or when the owner has dropped its request.
    assign release_cond = done | ~req[gnt_id];

    // Next state and next registered outputs. Defaults hold the current values.
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        gnt_next   = gnt;
        id_next    = gnt_id;
        valid_next = gnt_valid;
        case (state)
            IDLE: begin
                gnt_next   = '0;
                id_next    = '0;
                valid_next = 1'b0;
                if (found) begin
                    state_next       = BUSY;
                    gnt_next[winner] = 1'b1;
                    id_next          = winner;
                    valid_next       = 1'b1;
                    ptr_next         = (winner == W'(N-1)) ? '0 : winner + W'(1);
                end
            end
            BUSY: begin
                // Release takes priority over new requests. Those are
                // arbitrated in the following idle cycle.
                if (release_cond) begin
                    state_next = IDLE;
                    gnt_next   = '0;
                    id_next    = '0;
                    valid_next = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
                gnt_next   = '0;
                id_next    = '0;
                valid_next = 1'b0;
            end
        endcase
    end

    // State, pointer and output registers. Every output comes from a flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
        end else begin
            state     <= state_next;
            ptr       <= ptr_next;
            gnt       <= gnt_next;
            gnt_id    <= id_next;
            gnt_valid <= valid_next;
        end
    end

`ifdef RR_ONEHOT_ARBITER_CHECK_EN
    logic multi_hot;
    logic id_bad;
    logic valid_bad;
    logic err_q;

    // Clearing the lowest set bit leaves a non-zero value only when two or
    // more bits are set. An all-zero grant counts as legal.
    assign multi_hot = |(gnt & (gnt - N'(1)));
    assign id_bad    = (gnt == '0) ? (gnt_id != '0) : ~gnt[gnt_id];
    assign valid_bad = gnt_valid != (|gnt);

    // Sticky error flag. Only reset clears it.
    always_ff @(posedge clk) begin
        if (reset)
            err_q <= 1'b0;
        else
            err_q <= err_q | multi_hot | id_bad | valid_bad;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Testbench for rr_onehot_arbiter with N=4. Directed steps come first, then a
// randomized run. A behavioural model tracks owner, pointer and busy state
// using plain modulo arithmetic.
module tb_rr_onehot_arbiter;

    localparam int N = 4;
    localparam int W = 2;

`ifdef RR_ONEHOT_ARBITER_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic         clk;
    logic         reset;
    logic [N-1:0] req;
    logic         done;
    logic [N-1:0] gnt;
    logic         gnt_valid;
    logic [W-1:0] gnt_id;
    logic         err;

    rr_onehot_arbiter #(.N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state.
    bit m_busy  = 1'b0;
    int m_owner = 0;
    int m_ptr   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge, using the inputs sampled at that edge.
    task automatic model_edge(input logic r, input logic [N-1:0] q, input logic d);
        if (r) begin
            m_busy  = 1'b0;
            m_owner = 0;
            m_ptr   = 0;
        end else if (m_busy) begin
            if (d || !q[m_owner]) begin
                m_busy  = 1'b0;
                m_owner = 0;
            end
        end else if (q != '0) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (q[c]) begin
                    m_busy  = 1'b1;
                    m_owner = c;
                    m_ptr   = (c + 1) % N;
                    break;
                end
            end
        end
    endtask

    // Drive inputs at the negedge, take the edge, then compare 1 time unit later.
    task automatic step(input logic r, input logic [N-1:0] q, input logic d);
        @(negedge clk);
        reset = r;
        req   = q;
        done  = d;
        @(posedge clk);
        model_edge(r, q, d);
        #1;
        vectors++;
        chk("gnt",       32'(gnt),       m_busy ? (32'd1 << m_owner) : 32'd0);
        chk("gnt_valid", 32'(gnt_valid), 32'(m_busy));
        chk("gnt_id",    32'(gnt_id),    m_busy ? 32'(m_owner) : 32'd0);
        chk("err",       32'(err),       32'd0);
        chk("ptr",       32'(dut.ptr),   32'(m_ptr));
    endtask

    int order[$];
    int exp_order[5] = '{0, 1, 2, 3, 0};
    logic [N-1:0] rq;

    initial begin
        reset = 1'b1;
        req   = '0;
        done  = 1'b0;

        // Reset held for 2 cycles, then idle with no requests.
        step(1'b1, 4'b0000, 1'b0);
        step(1'b1, 4'b0000, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 4'b0000, 1'b0);

        // Single requester: grant at t+1, done at t+3, released at t+4, ptr=3.
        step(1'b0, 4'b0100, 1'b0);
        chk("single_gnt", 32'(gnt), 32'h4);
        chk("single_id",  32'(gnt_id), 32'd2);
        step(1'b0, 4'b0100, 1'b0);
        step(1'b0, 4'b0100, 1'b0);
        step(1'b0, 4'b0100, 1'b1);
        chk("single_release", 32'(gnt), 32'd0);
        chk("single_ptr", 32'(dut.ptr), 32'd3);
        step(1'b0, 4'b0000, 1'b1);   // done while idle is ignored

        // Fairness: all requesting, done pulsed on every grant.
        step(1'b1, 4'b0000, 1'b0);
        order.delete();
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 4'b1111, 1'b0);
            chk("fair_granted", 32'(gnt_valid), 32'd1);
            order.push_back(int'(gnt_id));
            step(1'b0, 4'b1111, 1'b1);
            chk("fair_gap", 32'(gnt_valid), 32'd0);
        end
        for (int i = 0; i < 5; i++)
            chk("fair_order", 32'(order[i]), 32'(exp_order[i]));

        // Wrap and pointer skip: reach ptr=3, then req=0011 grants 0, then 1.
        step(1'b1, 4'b0000, 1'b0);
        step(1'b0, 4'b0100, 1'b0);
        step(1'b0, 4'b0000, 1'b0);   // owner drops its request
        chk("wrap_ptr3", 32'(dut.ptr), 32'd3);
        step(1'b0, 4'b0011, 1'b0);
        chk("wrap_id0", 32'(gnt_id), 32'd0);
        chk("wrap_ptr1", 32'(dut.ptr), 32'd1);
        step(1'b0, 4'b0011, 1'b1);
        step(1'b0, 4'b0011, 1'b0);
        chk("wrap_id1", 32'(gnt_id), 32'd1);

        // Owner 1 drops req[1] without done: released on the next edge.
        step(1'b0, 4'b0001, 1'b0);
        chk("drop_release", 32'(gnt), 32'd0);

        // Reset mid-grant while gnt=1000.
        step(1'b0, 4'b1000, 1'b0);   // ptr=2 here, so requester 3 wins
        chk("mid_gnt", 32'(gnt), 32'h8);
        step(1'b1, 4'b1000, 1'b0);
        chk("mid_rst_gnt", 32'(gnt), 32'd0);
        chk("mid_rst_id",  32'(gnt_id), 32'd0);
        chk("mid_rst_ptr", 32'(dut.ptr), 32'd0);

        // Random run. Requests tend to persist, done is sparse, resets are rare.
        rq = '0;
        for (int i = 0; i < 600; i++) begin
            logic r, d;
            if ($urandom_range(0, 3) == 0) rq = N'($urandom_range(0, 15));
            r = ($urandom_range(0, 59) == 0);
            d = ($urandom_range(0, 3) == 0);
            step(r, rq, d);
        end

        // Checker: force an illegal two-hot grant while idle.
        step(1'b1, 4'b0000, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        req   = '0;
        done  = 1'b0;
        force dut.gnt = 4'b0110;
        @(posedge clk);
        #1;
        vectors++;
        chk("err_set", 32'(err), 32'(EXP_ERR));
        @(posedge clk);
        #1;
        vectors++;
        chk("err_forced_hold", 32'(err), 32'(EXP_ERR));
        @(negedge clk);
        release dut.gnt;
        @(posedge clk);
        #1;
        vectors++;
        chk("gnt_after_release", 32'(gnt), 32'd0);
        chk("err_sticky", 32'(err), 32'(EXP_ERR));
        @(posedge clk);
        #1;
        vectors++;
        chk("err_sticky2", 32'(err), 32'(EXP_ERR));
        model_edge(1'b1, 4'b0000, 1'b0);
        step(1'b1, 4'b0000, 1'b0);   // step also checks err=0 after reset
        step(1'b0, 4'b0010, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
